// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential radix-4 signed multiplier.
// Holds the controller state encoding, the partial-product width extension
// and the helper functions that derive step count and counter width from WB.
package seq_mult_pkg;

    // Controller states; encoding is fixed so other blocks and debug tools
    // can decode the raw state value.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A partial is A times a digit in [-2, 3]; two extra bits cover 3*A and
    // -2*A for the most negative A.
    localparam int PART_EXT = 2;

    // Number of radix-4 steps: one per multiplier bit pair.
    function automatic int step_count(input int wb);
        return wb / 2;
    endfunction

    // Width of the step counter, never less than one bit.
    function automatic int step_cnt_width(input int wb);
        int n;
        n = wb / 2;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_layer.sv
// Purpose : one radix-4 step - partial product A * digit, digit from a bit pair.
// Latency : purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports   : a_i (WA-bit signed multiplicand), b_low_i / b_high_i (multiplier
//           bit pair), last_i (bit pair holds the multiplier MSB),
//           partial_o (WA+2-bit signed partial).
module seq_mult_layer
    import seq_mult_pkg::*;
#(
    parameter int WA = 8
) (
    input  logic [WA-1:0]          a_i,
    input  logic                   b_low_i,
    input  logic                   b_high_i,
    input  logic                   last_i,
    output logic [WA+PART_EXT-1:0] partial_o
);

    localparam int PW = WA + PART_EXT;

    logic signed [PW-1:0] a_x1;
    logic signed [PW-1:0] a_x2;
    logic signed [PW-1:0] a_x3;

    assign a_x1 = {{PART_EXT{a_i[WA-1]}}, a_i};
    assign a_x2 = a_x1 <<< 1;
    assign a_x3 = a_x1 + a_x2;

    // Ordinary pairs carry weight +2 on the high bit. The pair containing
    // the multiplier MSB gives that bit weight -2, which is what makes the
    // whole multiplier read as two's complement.
    always_comb begin
        partial_o = '0;
        case ({last_i, b_high_i, b_low_i})
            3'b0_00: partial_o = '0;
            3'b0_01: partial_o = a_x1;
            3'b0_10: partial_o = a_x2;
            3'b0_11: partial_o = a_x3;
            3'b1_00: partial_o = '0;
            3'b1_01: partial_o = a_x1;
            3'b1_10: partial_o = -a_x2;
            3'b1_11: partial_o = a_x1 - a_x2;
            default: partial_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Purpose : sequential signed multiplier, WB/2 radix-4 steps per product.
// Latency : out_valid rises WB/2 cycles after the accepting edge.
// Backpressure: product held in DONE until out_ready; in_ready only in IDLE.
// Ports   : clk, rst (async active-high), flush (sync abort),
//           in_valid/in_ready/a_in/b_in (operand handshake),
//           out_valid/out_ready/product (result handshake), busy (RUN or DONE).
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WA = 8,
    parameter int WB = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WA-1:0]      a_in,
    input  logic [WB-1:0]      b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WA+WB-1:0]   product,
    output logic               busy
);

    localparam int N   = step_count(WB);
    localparam int KW  = step_cnt_width(WB);
    localparam int PW  = WA + PART_EXT;
    localparam int PRW = WA + WB;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t           state_q, state_d;
    logic [WA-1:0]    a_q, a_d;
    logic [WB-1:0]    b_q, b_d;
    logic [PRW-1:0]   acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;

    logic             accept;
    logic             last_step;
    logic             b_low;
    logic             b_high;
    logic [PW-1:0]    partial;
    logic [PRW-1:0]   partial_ext;
    logic [PRW-1:0]   partial_sh;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. flush wins over every handshake on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid)  state_d = RUN;
                RUN:     if (last_step) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default:                state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. All handshake outputs decode the registered state only,
    // so there is no combinational path from in_valid or out_ready.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        product   = (state_q == DONE) ? acc_q : '0;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign accept    = (state_q == IDLE) && in_valid && !flush;
    assign last_step = (k_q == K_LAST);

    // Bit pair for step k sits at b[2k+1:2k].
    assign b_low  = b_q[{k_q, 1'b0}];
    assign b_high = b_q[{k_q, 1'b1}];

    seq_mult_layer #(
        .WA (WA)
    ) u_layer (
        .a_i       (a_q),
        .b_low_i   (b_low),
        .b_high_i  (b_high),
        .last_i    (last_step),
        .partial_o (partial)
    );

    // Sign-extend to the product width, then weight by 4^k. Truncation to
    // PRW bits is exact because the true product always fits.
    assign partial_ext = {{(PRW - PW){partial[PW-1]}}, partial};
    assign partial_sh  = partial_ext << {k_q, 1'b0};

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        k_d   = k_q;
        if (flush) begin
            acc_d = '0;
            k_d   = '0;
        end else if (accept) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = '0;
            k_d   = '0;
        end else if (state_q == RUN) begin
            acc_d = acc_q + partial_sh;
            k_d   = last_step ? '0 : k_q + KW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int N  = WB / 2;
    localparam int PW = WA + WB;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a_in;
    logic [WB-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int checks = 0;
    int errors = 0;

    seq_mult_ctrl #(
        .WA (WA),
        .WB (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: one outstanding product, ready a fixed
    // number of edges after acceptance, released by out_ready.
    bit m_busy  = 1'b0;
    bit m_valid = 1'b0;
    int m_cnt   = 0;
    int m_prod  = 0;
    int m_del   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            m_prod  = 0;
        end else if (flush) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = N;
                m_prod = $signed(a_in) * $signed(b_in);
            end
        end else if (!m_valid) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_del   = m_del + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("mdl_in_ready",  longint'(in_ready),  longint'(!m_busy));
        chk("mdl_busy",      longint'(busy),      longint'(m_busy));
        chk("mdl_out_valid", longint'(out_valid), longint'(m_valid));
        chk("mdl_product",   longint'($signed(product)), m_valid ? longint'(m_prod) : 0);
    endtask

    // Compare on the falling edge, then advance one rising edge; inputs are
    // changed by the caller 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int a, input int b, input int exp, input string nm);
        a_in      = WA'(a);
        b_in      = WB'(b);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({nm, "_rdy"}, longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk({nm, "_early"}, longint'(out_valid), 0);
            tick();
        end
        chk({nm, "_valid"}, longint'(out_valid), 1);
        chk({nm, "_prod"}, longint'($signed(product)), longint'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_idle"}, longint'(in_ready), 1);
    endtask

    int base;
    int cyc;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;

        // Reset state
        #12;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy",      longint'(busy), 0);
        chk("rst_product",   longint'(product), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready",  longint'(in_ready), 1);

        // Literal products
        do_op(-128, -128, 16384, "m128sq");
        do_op(127, -1, -127, "p127m1");
        do_op(0, -77, 0, "zero");
        do_op(-1, -1, 1, "m1m1");

        // Hold in DONE with out_ready low; new operands must be ignored
        a_in = 8'd100; b_in = 8'hF9; in_valid = 1'b1;   // 100 * -7
        tick();
        in_valid = 1'b0;
        repeat (N) tick();
        a_in = 8'd3; b_in = 8'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_prod",  longint'($signed(product)), -700);
            chk("hold_rdy",   longint'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_rdy",   longint'(in_ready), 1);
        chk("hold_release_valid", longint'(out_valid), 0);

        // Flush at step k=2, with in_valid and out_ready also high
        a_in = 8'd77; b_in = 8'd55; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_rdy",  longint'(in_ready), 1);
        chk("flush_busy", longint'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_valid", longint'(out_valid), 0);
            tick();
        end
        // Flush in IDLE beats a simultaneous in_valid
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_busy", longint'(busy), 0);
        do_op(5, -3, -15, "after_flush");

        // Asynchronous reset mid-RUN
        a_in = 8'h9C; b_in = 8'd99; in_valid = 1'b1;    // -100 * 99
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_busy",      longint'(busy), 0);
        chk("arst_product",   longint'(product), 0);
        @(negedge clk);
        compare_all();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            chk("arst_no_valid", longint'(out_valid), 0);
            tick();
        end
        do_op(-100, 99, -9900, "after_rst");

        // Random back-to-back traffic with random consumer stalls
        base = m_del;
        cyc  = 0;
        while ((m_del - base) < 1000 && cyc < 40000) begin
            in_valid  = ($urandom_range(3) != 0);
            a_in      = WA'($urandom);
            b_in      = WB'($urandom);
            out_ready = 1'($urandom_range(1));
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_delivered", longint'(m_del - base), 1000);
        repeat (2 * N) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 SHALL have parameter WA, default 8, meaning multiplicand width in bits, signed, minimum 4.
REQ-002 SHALL have parameter WB, default 8, meaning multiplier width in bits, signed, even, minimum 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of any operation in progress.
REQ-006 SHALL have port in_valid, input, 1 bit: operands are offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-008 SHALL have port a_in, input, WA bits: signed multiplicand.
REQ-009 SHALL have port b_in, input, WB bits: signed multiplier.
REQ-010 SHALL have port out_valid, output, 1 bit: the product is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the product.
REQ-012 SHALL have port product, output, WA+WB bits: signed product a_in*b_in.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL assert in_ready only in IDLE; acceptance occurs on an edge where in_valid and in_ready are both high; at acceptance the block registers a_in and b_in, clears the accumulator, sets step counter k=0 and enters RUN.
REQ-016 SHALL, in RUN, process one step per cycle, N=WB/2 steps in total; step k SHALL use bit pair b[2k] (low) and b[2k+1] (high) of the registered multiplier.
REQ-017 SHALL use the partial A*(b_low+2*b_high) for steps k<N-1 and the partial A*(b_low-2*b_high) for step k=N-1, which applies the sign weight of the multiplier MSB.
REQ-018 SHALL form each partial sign-extended to WA+2 bits and SHALL add it to the accumulator at bit offset 2k, with all arithmetic in WA+WB bits two's complement and no overflow possible.
REQ-019 SHALL move from RUN to DONE on the edge completing step N-1; out_valid SHALL be high exactly N cycles after the acceptance edge (N=4 for WB=8).
REQ-020 SHALL, in DONE, hold out_valid high and product stable until an edge with out_ready=1, then return to IDLE.
REQ-021 SHALL drive product to the accumulator value in DONE and to 0 in every other state.
REQ-022 SHALL ignore in_valid outside IDLE; operands presented then are neither accepted nor stored.
REQ-023 SHALL, when flush=1 on an edge, enter IDLE and clear the accumulator, counter and out_valid, whatever the state; flush SHALL override in_valid and out_ready on that same edge.
REQ-024 SHALL produce no out_valid pulse for an aborted operation.
REQ-025 SHALL derive in_ready, out_valid and busy from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-026 SHALL, while rst=1, asynchronously force state=IDLE, accumulator=0, k=0, registered operands=0, out_valid=0, busy=0 and product=0; in_ready SHALL be 1 on the first edge after rst deasserts.
REQ-027 SHALL, when rst asserts mid-RUN, discard the operation and produce no output for it.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the step-count function N=WB/2 in the shared package seq_mult_pkg.
REQ-029 SHALL place the per-step arithmetic in one combinational sub-module, seq_mult_layer, which takes A, b_low, b_high and a last-step flag and outputs the WA+2-bit signed partial.
REQ-030 SHALL keep the FSM, counter, accumulator and handshake in seq_mult_ctrl.

Verification (WA=WB=8)
REQ-031 SHALL verify: a_in=-128, b_in=-128 accepted -> out_valid high 4 cycles later, product=16384.
REQ-032 SHALL verify: a_in=127, b_in=-1 -> product=-127; and a_in=0, b_in=-77 -> product=0.
REQ-033 SHALL verify: out_ready held low 5 cycles in DONE -> product and out_valid stable, in_ready=0, a new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 SHALL verify: flush at step k=2 -> IDLE next edge, no out_valid; then a_in=5, b_in=-3 -> product=-15.
REQ-035 SHALL verify: rst pulse mid-RUN -> all outputs 0 immediately, in_ready=1 after release, and the next operation is correct.
REQ-036 SHALL verify: 1000 random back-to-back operand pairs with random out_ready -> every product equals the reference a*b.
